divu_iter: RTL and testbench

Iterative 32-bit unsigned divider producing quotient and remainder by restoring division, BITS_PER_CYCLE quotient bits per clock. It inverts the datapath's adder: each step is a trial subtraction on the 32-bit carry-lookahead adder (divisor inverted, carry-in 1). It sits beside the ALU as a multi-cycle functional unit behind a valid/ready handshake, so the pipeline can stall on it.

---
 rtl/divu_pkg.sv | 40 ++++
 rtl/divu_step.sv | 26 ++
 rtl/divu_iter.sv | 88 ++++++++
 tb/tb_divu_iter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/divu_pkg.sv
// Shared types and helpers for the iterative unsigned divider.
// Holds the FSM encoding, the datapath width and the 32-bit carry-lookahead adder.
package divu_pkg;

    localparam int WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int cnt_width(input int bpc);
        return ((WIDTH / bpc) > 1) ? $clog2(WIDTH / bpc) : 1;
    endfunction

    // Returns {carry_out, sum}. Four-bit lookahead groups with carry passed between groups.
    function automatic logic [WIDTH:0] cla_add32(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic             cin);
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
        logic [WIDTH:0]   c;
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = cin;
        for (int k = 0; k < WIDTH; k += 4) begin
            c[k+1] = g[k] | (p[k] & c[k]);
            c[k+2] = g[k+1] | (p[k+1] & g[k]) | (p[k+1] & p[k] & c[k]);
            c[k+3] = g[k+2] | (p[k+2] & g[k+1]) | (p[k+2] & p[k+1] & g[k])
                   | (p[k+2] & p[k+1] & p[k] & c[k]);
            c[k+4] = g[k+3] | (p[k+3] & g[k+2]) | (p[k+3] & p[k+2] & g[k+1])
                   | (p[k+3] & p[k+2] & p[k+1] & g[k])
                   | (p[k+3] & p[k+2] & p[k+1] & p[k] & c[k]);
        end
        return {c[WIDTH], p ^ c[WIDTH-1:0]};
    endfunction

endpackage

// File: rtl/divu_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the
// divisor on the CLA adder, keep the difference when it does not borrow.
module divu_step
    import divu_pkg::*;
(
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_dq,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_dq
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_sum;
    logic           w_ge;

    assign w_shift = {i_rem, i_dq[WIDTH-1]};
    assign w_sum   = cla_add32(w_shift[WIDTH-1:0], ~i_divisor, 1'b1);

    // rem' fits in 33 bits and stays below 2*divisor, so the low 32 bits of the
    // difference are exact whenever rem' >= divisor.
    assign w_ge    = w_shift[WIDTH] | w_sum[WIDTH];
    assign o_rem   = w_ge ? w_sum[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign o_dq    = {i_dq[WIDTH-2:0], w_ge};

endmodule

// File: rtl/divu_iter.sv
// Iterative 32-bit unsigned divider, BITS_PER_CYCLE quotient bits per clock,
// with valid/ready handshakes on both operand and result sides.
module divu_iter
    import divu_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder
);

    localparam int N     = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = cnt_width(BITS_PER_CYCLE);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH-1:0] r_dq;
    logic [WIDTH-1:0] r_rem;

    logic [WIDTH-1:0] w_rem [BITS_PER_CYCLE+1];
    logic [WIDTH-1:0] w_dq  [BITS_PER_CYCLE+1];

    assign w_rem[0] = r_rem;
    assign w_dq[0]  = r_dq;

    // Steps are chained combinationally, most significant quotient bit first.
    for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_step
        divu_step u_step (
            .i_rem     (w_rem[gi]),
            .i_dq      (w_dq[gi]),
            .i_divisor (r_divisor),
            .o_rem     (w_rem[gi+1]),
            .o_dq      (w_dq[gi+1])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_dq    <= '0;
            r_rem   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_valid) begin
                        r_divisor <= i_divisor;
                        r_dq      <= i_dividend;
                        r_rem     <= '0;
                        r_cnt     <= '0;
                        r_state   <= BUSY;
                    end
                end
                BUSY: begin
                    r_dq  <= w_dq[BITS_PER_CYCLE];
                    r_rem <= w_rem[BITS_PER_CYCLE];
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(N - 1)) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (o_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign i_ready     = (r_state == IDLE);
    assign o_valid     = (r_state == DONE);
    assign o_quotient  = r_dq;
    assign o_remainder = r_rem;

endmodule

// File: tb/tb_divu_iter.sv
// Bench for divu_iter: one instance at 1 bit/cycle, one at 4 bits/cycle,
// checked against a plain-arithmetic division model.
module tb_divu_iter;

    logic        clk = 1'b0;
    logic        rst1 = 1'b0, rst4 = 1'b0;
    logic        v1 = 1'b0, v4 = 1'b0;
    logic        rdy1, rdy4;
    logic [31:0] dd1 = '0, dv1 = '0, dd4 = '0, dv4 = '0;
    logic        ov1, ov4;
    logic        or1 = 1'b0, or4 = 1'b0;
    logic [31:0] q1, r1, q4, r4;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    divu_iter #(.BITS_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst(rst1), .i_valid(v1), .i_ready(rdy1),
        .i_dividend(dd1), .i_divisor(dv1), .o_valid(ov1), .o_ready(or1),
        .o_quotient(q1), .o_remainder(r1)
    );

    divu_iter #(.BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst(rst4), .i_valid(v4), .i_ready(rdy4),
        .i_dividend(dd4), .i_divisor(dv4), .o_valid(ov4), .o_ready(or4),
        .o_quotient(q4), .o_remainder(r4)
    );

    // Reference: RISC-V DIVU/REMU semantics, divide by zero gives all ones / dividend.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return {32'hFFFF_FFFF, a};
        return {a / b, a % b};
    endfunction

    // Drives one operation into instance w (1 or 4) and waits for its result.
    task automatic op(input int w, input logic [31:0] a, input logic [31:0] b,
                      input bit take, output logic [31:0] q, output logic [31:0] r,
                      output int lat, output int acc, output bit busy_rdy_ok);
        int g;
        g = 0;
        while (!(w == 1 ? rdy1 : rdy4) && g < 64) begin
            @(posedge clk); #1; g++;
        end
        if (w == 1) begin dd1 = a; dv1 = b; v1 = 1'b1; or1 = take; end
        else        begin dd4 = a; dv4 = b; v4 = 1'b1; or4 = take; end
        @(posedge clk); #1;
        acc = cyc;
        if (w == 1) begin v1 = 1'b0; dd1 = $urandom; dv1 = $urandom; end
        else        begin v4 = 1'b0; dd4 = $urandom; dv4 = $urandom; end
        lat = 0;
        busy_rdy_ok = 1'b1;
        while (!(w == 1 ? ov1 : ov4) && lat < 100) begin
            if (w == 1 ? rdy1 : rdy4) busy_rdy_ok = 1'b0;
            @(posedge clk); #1; lat++;
        end
        q = (w == 1) ? q1 : q4;
        r = (w == 1) ? r1 : r4;
        if (take) begin
            @(posedge clk); #1;
            if (w == 1) or1 = 1'b0; else or4 = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst1 = 1'b1; rst4 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp += 4;
        if ({rdy1, ov1} !== 2'b10) begin n_bad++; $display("FAIL reset_hs1 got rdy/ov=%b want 10", {rdy1, ov1}); end
        if ({q1, r1} !== 64'd0) begin n_bad++; $display("FAIL reset_out1 got q=%h r=%h want 0 0", q1, r1); end
        if ({rdy4, ov4} !== 2'b10) begin n_bad++; $display("FAIL reset_hs4 got rdy/ov=%b want 10", {rdy4, ov4}); end
        if ({q4, r4} !== 64'd0) begin n_bad++; $display("FAIL reset_out4 got q=%h r=%h want 0 0", q4, r4); end
        rst1 = 1'b0; rst4 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [31:0] q, r;
        int lat, acc;
        bit ok;
        op(1, 32'd100, 32'd7, 1'b1, q, r, lat, acc, ok);
        n_cmp += 5;
        if (q !== 32'd14) begin n_bad++; $display("FAIL basic_q got %0d want 14", q); end
        if (r !== 32'd2) begin n_bad++; $display("FAIL basic_r got %0d want 2", r); end
        if (lat !== 32) begin n_bad++; $display("FAIL basic_latency got %0d want 32", lat); end
        if (ok !== 1'b1) begin n_bad++; $display("FAIL basic_busy_ready got i_ready high want low"); end
        if ({rdy1, ov1} !== 2'b10) begin n_bad++; $display("FAIL basic_return_idle got rdy/ov=%b want 10", {rdy1, ov1}); end
    endtask

    task automatic test_corners();
        logic [31:0] a [3] = '{32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'd3};
        logic [31:0] b [3] = '{32'd0, 32'd1, 32'd10};
        logic [31:0] q, r;
        logic [63:0] e;
        int lat, acc;
        bit ok;
        for (int i = 0; i < 3; i++) begin
            op(1, a[i], b[i], 1'b1, q, r, lat, acc, ok);
            e = ref_div(a[i], b[i]);
            n_cmp += 2;
            if (q !== e[63:32]) begin n_bad++; $display("FAIL corner_q[%0d] got %h want %h", i, q, e[63:32]); end
            if (r !== e[31:0]) begin n_bad++; $display("FAIL corner_r[%0d] got %h want %h", i, r, e[31:0]); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] a, b, q, r;
        logic [63:0] e;
        int lat, acc;
        bit ok;
        a = $urandom;
        b = ($urandom >> 8) | 32'd1;
        e = ref_div(a, b);
        op(1, a, b, 1'b0, q, r, lat, acc, ok);
        n_cmp += 2;
        if (q !== e[63:32]) begin n_bad++; $display("FAIL bp_q got %h want %h", q, e[63:32]); end
        if (r !== e[31:0]) begin n_bad++; $display("FAIL bp_r got %h want %h", r, e[31:0]); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_cmp += 2;
            if ({rdy1, ov1} !== 2'b01) begin n_bad++; $display("FAIL bp_hold_hs[%0d] got rdy/ov=%b want 01", i, {rdy1, ov1}); end
            if ({q1, r1} !== e) begin n_bad++; $display("FAIL bp_hold_out[%0d] got %h %h want %h %h", i, q1, r1, e[63:32], e[31:0]); end
        end
        or1 = 1'b1;
        @(posedge clk); #1;
        or1 = 1'b0;
        n_cmp++;
        if ({rdy1, ov1} !== 2'b10) begin n_bad++; $display("FAIL bp_release got rdy/ov=%b want 10", {rdy1, ov1}); end
        op(1, 32'd81, 32'd9, 1'b1, q, r, lat, acc, ok);
        n_cmp++;
        if ({q, r} !== {32'd9, 32'd0}) begin n_bad++; $display("FAIL bp_next got %0d %0d want 9 0", q, r); end
    endtask

    task automatic test_reset_busy();
        logic [31:0] q, r;
        int lat, acc;
        bit ok;
        dd1 = 32'h1234_5678; dv1 = 32'd3; v1 = 1'b1;
        @(posedge clk); #1;
        v1 = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst1 = 1'b1;
        @(posedge clk); #1;
        rst1 = 1'b0;
        n_cmp += 2;
        if ({rdy1, ov1} !== 2'b10) begin n_bad++; $display("FAIL rstbusy_hs got rdy/ov=%b want 10", {rdy1, ov1}); end
        if ({q1, r1} !== 64'd0) begin n_bad++; $display("FAIL rstbusy_out got %h %h want 0 0", q1, r1); end
        op(1, 32'd50, 32'd5, 1'b1, q, r, lat, acc, ok);
        n_cmp += 2;
        if (q !== 32'd10) begin n_bad++; $display("FAIL rstbusy_q got %0d want 10", q); end
        if (r !== 32'd0) begin n_bad++; $display("FAIL rstbusy_r got %0d want 0", r); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] q, r;
        int lat, acc0, acc1;
        bit ok;
        op(4, 32'd1000, 32'd33, 1'b1, q, r, lat, acc0, ok);
        op(4, 32'd77, 32'd77, 1'b1, q, r, lat, acc1, ok);
        n_cmp += 2;
        if (acc1 - acc0 !== 10) begin n_bad++; $display("FAIL b2b_interval got %0d want 10", acc1 - acc0); end
        if ({q, r} !== {32'd1, 32'd0}) begin n_bad++; $display("FAIL b2b_equal got %0d %0d want 1 0", q, r); end
    endtask

    task automatic test_random4();
        logic [31:0] a, b, q, r;
        logic [63:0] e;
        int lat, acc;
        bit ok;
        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            case (i % 5)
                0: b = $urandom;
                1: begin a = a >> 1; b = a + 32'd1 + ($urandom % 1000); end
                2: b = a;
                3: b = $urandom_range(1, 15);
                default: b = (i % 50 == 4) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
            endcase
            e = ref_div(a, b);
            op(4, a, b, 1'b1, q, r, lat, acc, ok);
            n_cmp += 4;
            if (q !== e[63:32]) begin n_bad++; $display("FAIL rand_q[%0d] %h/%h got %h want %h", i, a, b, q, e[63:32]); end
            if (r !== e[31:0]) begin n_bad++; $display("FAIL rand_r[%0d] %h/%h got %h want %h", i, a, b, r, e[31:0]); end
            if (lat !== 8) begin n_bad++; $display("FAIL rand_latency[%0d] got %0d want 8", i, lat); end
            if (ok !== 1'b1) begin n_bad++; $display("FAIL rand_busy_ready[%0d] got i_ready high want low", i); end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout at cycle %0d want completion", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_backpressure();
        test_reset_busy();
        test_back_to_back();
        test_random4();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
